// File: rtl/fifo_pkg.sv
// Shared widths and helpers for the parametrised synchronous FIFO.
// The count typedef matches the default depth so benches and wrappers agree on widths.
package fifo_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_DEPTH  = 16;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  typedef logic [cnt_w(DEF_DEPTH)-1:0] count_t;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port.
// The storage is deliberately not reset.
module fifo_ram #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags, sticky error
// flags and an optional first-word-fall-through read path.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int ALM_FULL_TH  = DEPTH - 2,
  parameter int ALM_EMPTY_TH = 2,
  parameter bit FWFT         = 1'b0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_wren,
  input  logic [DATA_W-1:0]        i_wrdata,
  input  logic                     i_rden,
  input  logic                     i_err_clr,
  output logic [DATA_W-1:0]        o_rddata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_alm_full,
  output logic                     o_alm_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 4 || ALM_FULL_TH < 1 || ALM_FULL_TH > DEPTH ||
      ALM_EMPTY_TH < 0 || ALM_EMPTY_TH > DEPTH - 1) begin : g_param_check
    $error("fifo_sync_param: illegal DEPTH or threshold parameters");
  end

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_nxt;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] ram_rdata;

  assign wr_acc = i_wren & ~o_full;
  assign rd_acc = i_rden & ~o_empty;

  always_comb begin
    count_nxt = o_count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = o_count + CW'(1);
      2'b01:   count_nxt = o_count - CW'(1);
      default: count_nxt = o_count;
    endcase
  end

  // Flags are registered from the next count so they move together with o_count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_count     <= '0;
      o_full      <= 1'b0;
      o_empty     <= 1'b1;
      o_alm_full  <= 1'b0;
      o_alm_empty <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      o_count     <= count_nxt;
      o_full      <= (count_nxt == CW'(DEPTH));
      o_empty     <= (count_nxt == '0);
      o_alm_full  <= (count_nxt >= CW'(ALM_FULL_TH));
      o_alm_empty <= (count_nxt <= CW'(ALM_EMPTY_TH));
    end
  end

  // A new error event takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wren & o_full)      o_overflow <= 1'b1;
      else if (i_err_clr)       o_overflow <= 1'b0;
      if (i_rden & o_empty)     o_underflow <= 1'b1;
      else if (i_err_clr)       o_underflow <= 1'b0;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (i_wrdata),
    .rd_addr (rd_ptr),
    .rd_data (ram_rdata)
  );

  if (FWFT) begin : g_fwft
    assign o_rddata = ram_rdata;
  end else begin : g_reg_read
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        o_rddata <= '0;
      end else if (rd_acc) begin
        o_rddata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: one registered-read and one FWFT instance share stimulus.
module tb_fifo_sync_param;
  import fifo_pkg::*;

  localparam int DW = 16;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wren = 1'b0;
  logic [DW-1:0] wrdata = '0;
  logic          rden = 1'b0;
  logic          err_clr = 1'b0;

  logic [DW-1:0] rddata0, rddata1;
  logic          full0, empty0, alm_full0, alm_empty0, ovf0, udf0;
  logic          full1, empty1, alm_full1, alm_empty1, ovf1, udf1;
  count_t        count0, count1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden),
    .i_err_clr(err_clr), .o_rddata(rddata0), .o_full(full0), .o_empty(empty0),
    .o_alm_full(alm_full0), .o_alm_empty(alm_empty0), .o_count(count0),
    .o_overflow(ovf0), .o_underflow(udf0)
  );

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(1'b1)) dut1 (
    .clk(clk), .rstn(rstn), .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden),
    .i_err_clr(err_clr), .o_rddata(rddata1), .o_full(full1), .o_empty(empty1),
    .o_alm_full(alm_full1), .o_alm_empty(alm_empty1), .o_count(count1),
    .o_overflow(ovf1), .o_underflow(udf1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [DW-1:0] data, input logic rd, input logic clr);
    wren    = wr;
    wrdata  = data;
    rden    = rd;
    err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #12;
    checkOutput("rst_count", 32'(count0), 0);
    checkOutput("rst_empty", 32'(empty0), 1);
    checkOutput("rst_alm_empty", 32'(alm_empty0), 1);
    checkOutput("rst_full", 32'(full0), 0);
    checkOutput("rst_alm_full", 32'(alm_full0), 0);
    checkOutput("rst_ovf", 32'(ovf0), 0);
    checkOutput("rst_udf", 32'(udf0), 0);
    checkOutput("rst_rddata", 32'(rddata0), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Fill with 1..16, then drain in order.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
      checkOutput("t1_wr_count", 32'(count0), 32'(i));
      checkOutput("t1_alm_full", 32'(alm_full0), (i >= 14) ? 1 : 0);
      checkOutput("t1_full", 32'(full0), (i == 16) ? 1 : 0);
      checkOutput("t1_empty", 32'(empty0), 0);
    end
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("t1_rd_data", 32'(rddata0), 32'(k));
      checkOutput("t1_rd_count", 32'(count0), 32'(16 - k));
      checkOutput("t1_alm_empty", 32'(alm_empty0), (16 - k <= 2) ? 1 : 0);
    end
    checkOutput("t1_end_empty", 32'(empty0), 1);
    checkOutput("t1_no_udf", 32'(udf0), 0);

    // Simultaneous request while full: read wins, write dropped.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, DW'(32'h20 + i), 1'b0, 1'b0);
    checkOutput("t2_full", 32'(full0), 1);
    applyStimulus(1'b1, 16'h00EE, 1'b1, 1'b0);
    checkOutput("t2_count", 32'(count0), 15);
    checkOutput("t2_ovf", 32'(ovf0), 1);
    checkOutput("t2_first", 32'(rddata0), 32'h20);
    checkOutput("t2_full_off", 32'(full0), 0);
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("t2_data", 32'(rddata0), 32'h20 + i);
    end
    checkOutput("t2_empty", 32'(empty0), 1);
    checkOutput("t2_ovf_sticky", 32'(ovf0), 1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t2_ovf_clr", 32'(ovf0), 0);

    // Simultaneous request while empty: write wins, read flagged.
    applyStimulus(1'b1, 16'h00AB, 1'b1, 1'b0);
    checkOutput("t3_count", 32'(count0), 1);
    checkOutput("t3_udf", 32'(udf0), 1);
    checkOutput("t3_hold", 32'(rddata0), 32'h2F);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t3_data", 32'(rddata0), 32'hAB);
    checkOutput("t3_empty", 32'(empty0), 1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t3_udf_clr", 32'(udf0), 0);

    // Steady state at count 8 across pointer wrap.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, DW'(32'h40 + i), 1'b0, 1'b0);
    checkOutput("t4_count8", 32'(count0), 8);
    for (int j = 0; j < 40; j++) begin
      applyStimulus(1'b1, DW'(32'h48 + j), 1'b1, 1'b0);
      checkOutput("t4_count", 32'(count0), 8);
      checkOutput("t4_data", 32'(rddata0), 32'h40 + j);
      checkOutput("t4_flags", {28'd0, full0, empty0, alm_full0, alm_empty0}, 0);
    end
    for (int j = 40; j < 48; j++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("t4_drain", 32'(rddata0), 32'h40 + j);
    end
    checkOutput("t4_empty", 32'(empty0), 1);
    checkOutput("t4_no_err", {30'd0, ovf0, udf0}, 0);

    // FWFT: head visible as soon as empty falls.
    applyStimulus(1'b1, 16'h0055, 1'b0, 1'b0);
    checkOutput("t5_empty_fall", 32'(empty1), 0);
    checkOutput("t5_fwft_data", 32'(rddata1), 32'h55);
    checkOutput("t5_reg_hold", 32'(rddata0), 32'h6F);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t5_pop_empty", 32'(empty1), 1);
    checkOutput("t5_reg_data", 32'(rddata0), 32'h55);

    // Asynchronous reset mid-stream with count 9 and overflow set.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, DW'(32'h80 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h00FF, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t6_pre_count", 32'(count0), 9);
    checkOutput("t6_pre_ovf", 32'(ovf0), 1);
    checkOutput("t6_fwft_head", 32'(rddata1), 32'h87);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("t6_rst_count", 32'(count0), 0);
    checkOutput("t6_rst_empty", 32'(empty0), 1);
    checkOutput("t6_rst_alm_empty", 32'(alm_empty0), 1);
    checkOutput("t6_rst_err", {30'd0, ovf0, udf0}, 0);
    checkOutput("t6_rst_fwft_count", 32'(count1), 0);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0001, 1'b0, 1'b1);
    checkOutput("t6_set_wins", 32'(ovf0), 1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t6_clr", 32'(ovf0), 0);
    checkOutput("t6_count_full", 32'(count0), 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO. It is the successor to the fixed 128-bit FIFO behind the existing fifo_interface, with configurable width, depth and almost-full/almost-empty thresholds. It adds an occupancy count, sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) read mode. It sits between producer and consumer agents on the same clock domain and keeps the existing i_wren/i_rden/o_full/o_empty signal set.

Parameters:
DATA_W, 128, data width in bits (≥1)
DEPTH, 16, number of entries; power of two, ≥4
ALM_FULL_TH, DEPTH-2, o_alm_full asserted when count ≥ ALM_FULL_TH (1..DEPTH)
ALM_EMPTY_TH, 2, o_alm_empty asserted when count ≤ ALM_EMPTY_TH (0..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = head word presented without a read request

Ports:
clk  in  1  clock, all logic on the rising edge
rstn  in  1  asynchronous active-low reset
i_wren  in  1  write request
i_wrdata  in  DATA_W  write data
i_rden  in  1  read request
i_err_clr  in  1  clears the sticky error flags
o_rddata  out  DATA_W  read data
o_full  out  1  count == DEPTH
o_empty  out  1  count == 0
o_alm_full  out  1  count ≥ ALM_FULL_TH
o_alm_empty  out  1  count ≤ ALM_EMPTY_TH
o_count  out  $clog2(DEPTH)+1  current occupancy
o_overflow  out  1  sticky: write attempted while full
o_underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rstn low, asynchronous):
  - pointers = 0, o_count = 0
  - o_empty = 1, o_alm_empty = 1, o_full = 0, o_alm_full = 0
  - o_overflow = 0, o_underflow = 0
  - FWFT=0: o_rddata = 0
  - Storage array is not reset.
- Accept rules:
  - wr_acc = i_wren & ~o_full
  - rd_acc = i_rden & ~o_empty
  - Rejected requests have no effect on pointers, count or storage.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Each increments on its own accept.
- Count update:
  - wr_acc only: +1
  - rd_acc only: -1
  - both, or neither: unchanged
- Flags are registered and computed from next-count, so they change in the same cycle as o_count. There is no lag.
- Simultaneous request while full: read accepted, write rejected (no bypass). Count becomes DEPTH-1, o_overflow sets.
- Simultaneous request while empty: write accepted, read rejected. Count becomes 1, o_underflow sets.
- Simultaneous request at 0 < count < DEPTH: both accepted, count unchanged, data order preserved.
- FWFT=0:
  - On rd_acc, o_rddata loads mem[rd_ptr] at that edge, i.e. it is valid the cycle after i_rden.
  - Otherwise o_rddata holds its value.
- FWFT=1:
  - o_rddata = mem[rd_ptr] continuously, combinational from the array.
  - It shows the head word once o_empty deasserts.
  - rd_acc pops the word and exposes the next one at the following cycle.
  - Value while empty is don't-care.
- Errors:
  - o_overflow sets on i_wren & o_full; o_underflow sets on i_rden & o_empty.
  - Both are sticky until i_err_clr.
  - If a set and i_err_clr occur in the same cycle, set wins.
- Write with empty FIFO: o_empty deasserts at the next edge (count 1). In FWFT mode data is visible in that same cycle.
- Parameter checks: elaboration-time $error if DEPTH is not a power of two, DEPTH < 4, or a threshold is out of range.

Decomposition:
- Shared package fifo_pkg:
  - function clog2-based width helper
  - localparams for default DEPTH/DATA_W
  - typedef for the count type, so the interface and testbench share widths
- One sub-module, fifo_ram: DEPTH×DATA_W register array.
  - One synchronous write port.
  - One asynchronous read port.
  - fifo_sync_param adds the output register for FWFT=0.
- fifo_interface is generalised to be parameterised by DATA_W and DEPTH, and adds o_count and the error flags to m_cb.

Test Plan:
1. DEPTH=16, FWFT=0: write 0x1..0x10 over 16 cycles → o_full=1 after the 16th edge, o_alm_full=1 from count 14, o_count=16; read 16 → data 0x1..0x10 in order, each one cycle after i_rden, o_empty=1 at end.
2. Full FIFO, i_wren=i_rden=1 for one cycle → o_count=15, o_overflow=1, written word absent from later reads.
3. Empty FIFO, i_wren=i_rden=1 with data 0xAB → o_count=1, o_underflow=1, next read returns 0xAB.
4. count=8, simultaneous wr/rd for 40 cycles spanning pointer wrap → o_count stays 8, flags constant, all data returned in order.
5. FWFT=1: single write 0x55 → o_rddata=0x55 in the cycle o_empty falls, before any i_rden; pop → o_empty=1 next cycle.
6. Assert rstn low mid-stream with count=9 and o_overflow=1 → immediately o_count=0, o_empty=1, o_alm_empty=1, errors=0. Then i_err_clr with a concurrent overflow → o_overflow stays 1.
